// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizes, host FSM states and chunk packing for the systolic host controller
package systolic_pkg;

  localparam int N              = 4;
  localparam int DATA_W         = 8;
  localparam int ACC_W          = 32;
  localparam int CHUNK_W        = 64;
  localparam int NUM_IN_CHUNKS  = 4;
  localparam int NUM_OUT_CHUNKS = 8;

  typedef enum logic [2:0] {IDLE, KICK, SETUP, STROBE, GAP, RECV} host_state_t;

  // Chunk k carries row k of A in the upper half and column k of B in the lower half.
  function automatic logic [CHUNK_W-1:0] pack_chunk(input logic [N*N*DATA_W-1:0] a,
                                                    input logic [N*N*DATA_W-1:0] b,
                                                    input logic [1:0]            k);
    logic [CHUNK_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c[CHUNK_W-1-DATA_W*i -: DATA_W]   = a[DATA_W*(N*int'(k)+i) +: DATA_W];
      c[CHUNK_W/2-1-DATA_W*i -: DATA_W] = b[DATA_W*(N*i+int'(k)) +: DATA_W];
    end
    return c;
  endfunction

endpackage

// File: rtl/systolic_rx_collect.sv
// rtl/systolic_rx_collect.sv - result chunk capture, timeout tracking and result storage
module systolic_rx_collect
  import systolic_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     acc_out_valid,
  input  logic [CHUNK_W-1:0]       acc_final_data_out,
  output logic                     last,
  output logic                     done,
  output logic                     err,
  output logic [N*N*ACC_W-1:0]     result
);

  logic [2:0] j;
  logic [7:0] tcnt;
  logic       live;
  logic       cap;

  // Once done or err is raised the job is over; nothing more is captured or counted.
  assign live = en && !done && !err;
  assign cap  = live && acc_out_valid;
  // Flags the cycle whose edge ends the receive phase, so the top can drop ready in time.
  assign last = live && (cap ? (j == 3'(NUM_OUT_CHUNKS-1)) : (tcnt == 8'(TIMEOUT-1)));

  // Store each accepted chunk as two elements, count idle cycles, pulse done or err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j      <= '0;
      tcnt   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (clr) begin
        j      <= '0;
        tcnt   <= '0;
        result <= '0;
      end else if (cap) begin
        // Upper word is element 2j and sits at the lower address of the pair.
        result[CHUNK_W*j +: CHUNK_W] <= {acc_final_data_out[ACC_W-1:0],
                                         acc_final_data_out[CHUNK_W-1:ACC_W]};
        j    <= j + 3'd1;
        tcnt <= '0;
        if (j == 3'(NUM_OUT_CHUNKS-1)) done <= 1'b1;
      end else if (live) begin
        tcnt <= tcnt + 8'd1;
        if (tcnt == 8'(TIMEOUT-1)) err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_host_ctrl.sv
// rtl/systolic_host_ctrl.sv - host-side job sequencer for the 4x4 int8 systolic accelerator
module systolic_host_ctrl
  import systolic_pkg::*;
#(
  parameter int GAP     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N*N*DATA_W-1:0]    a_mat,
  input  logic [N*N*DATA_W-1:0]    b_mat,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [N*N*ACC_W-1:0]     result,
  output logic                     acc_valid_in,
  output logic [CHUNK_W-1:0]       acc_data_in,
  output logic                     acc_src_valid,
  output logic                     acc_src_ready,
  input  logic                     acc_out_valid,
  input  logic [CHUNK_W-1:0]       acc_final_data_out
);

  host_state_t             state;
  logic [N*N*DATA_W-1:0]   a_q;
  logic [N*N*DATA_W-1:0]   b_q;
  logic [1:0]              k;
  logic [3:0]              gap_cnt;
  logic                    rx_last;
  logic                    rx_clr;
  logic                    rx_en;

  assign rx_clr = (state == IDLE) && start;
  assign rx_en  = (state == RECV);

  // Step through kick, four setup/strobe/gap rounds and the receive phase; outputs are
  // registered for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      k             <= '0;
      gap_cnt       <= '0;
      busy          <= 1'b0;
      acc_valid_in  <= 1'b0;
      acc_data_in   <= '0;
      acc_src_valid <= 1'b0;
      acc_src_ready <= 1'b0;
    end else begin
      acc_valid_in  <= 1'b0;
      acc_src_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q          <= a_mat;
            b_q          <= b_mat;
            k            <= '0;
            busy         <= 1'b1;
            acc_valid_in <= 1'b1;
            state        <= KICK;
          end
        end
        KICK: begin
          acc_data_in <= pack_chunk(a_q, b_q, 2'd0);
          state       <= SETUP;
        end
        SETUP: begin
          acc_src_valid <= 1'b1;
          state         <= STROBE;
        end
        STROBE: begin
          gap_cnt <= '0;
          state   <= systolic_pkg::GAP;
        end
        systolic_pkg::GAP: begin
          if (gap_cnt == 4'(GAP-1)) begin
            if (k == 2'(NUM_IN_CHUNKS-1)) begin
              acc_src_ready <= 1'b1;
              state         <= RECV;
            end else begin
              k           <= k + 2'd1;
              acc_data_in <= pack_chunk(a_q, b_q, k + 2'd1);
              state       <= SETUP;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        RECV: begin
          // The done/err pulse cycle is still busy, so a start there is not taken.
          if (rx_last) acc_src_ready <= 1'b0;
          if (done || err) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  systolic_rx_collect #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk                (clk),
    .reset              (reset),
    .clr                (rx_clr),
    .en                 (rx_en),
    .acc_out_valid      (acc_out_valid),
    .acc_final_data_out (acc_final_data_out),
    .last               (rx_last),
    .done               (done),
    .err                (err),
    .result             (result)
  );

endmodule

// File: tb/tb_systolic_host_ctrl.sv
// tb/tb_systolic_host_ctrl.sv - self-checking bench for systolic_host_ctrl
module tb_systolic_host_ctrl;

  localparam int GAP_T = 3;
  localparam int TO_T  = 64;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int           pat;
    int           stop;
    bit           restart;
    logic [31:0]  c00, c03, c30, c33;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] a_mat = '0;
  logic [127:0] b_mat = '0;
  logic         busy, done, err, acc_valid_in, acc_src_valid, acc_src_ready;
  logic [511:0] result;
  logic [63:0]  acc_data_in;
  logic         acc_out_valid = 1'b0;
  logic [63:0]  acc_final_data_out = '0;

  logic         start_g = 1'b0;
  logic         busy_g, done_g, err_g, acc_valid_in_g, acc_src_valid_g, acc_src_ready_g;
  logic [511:0] result_g;
  logic [63:0]  acc_data_in_g;
  logic         acc_out_valid_g = 1'b0;
  logic [63:0]  acc_final_data_out_g = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_chunk_q[$];
  logic [31:0] exp_elem_q[$];
  logic [63:0] seen_ch[4];
  logic [31:0] m_c[16];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  systolic_host_ctrl #(.GAP(GAP_T), .TIMEOUT(TO_T)) dut (
    .clk(clk), .reset(reset), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy), .done(done), .err(err), .result(result),
    .acc_valid_in(acc_valid_in), .acc_data_in(acc_data_in),
    .acc_src_valid(acc_src_valid), .acc_src_ready(acc_src_ready),
    .acc_out_valid(acc_out_valid), .acc_final_data_out(acc_final_data_out)
  );

  systolic_host_ctrl #(.GAP(1), .TIMEOUT(TO_T)) dut_g1 (
    .clk(clk), .reset(reset), .start(start_g), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy_g), .done(done_g), .err(err_g), .result(result_g),
    .acc_valid_in(acc_valid_in_g), .acc_data_in(acc_data_in_g),
    .acc_src_valid(acc_src_valid_g), .acc_src_ready(acc_src_ready_g),
    .acc_out_valid(acc_out_valid_g), .acc_final_data_out(acc_final_data_out_g)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] el(input logic [127:0] m, input int r, input int c);
    return m[8*(4*r+c) +: 8];
  endfunction

  function automatic logic [31:0] gold(input logic [127:0] a, input logic [127:0] b,
                                       input int r, input int c);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 4; i++) s += 32'(el(a, r, i)) * 32'(el(b, i, c));
    return s;
  endfunction

  function automatic logic [63:0] exp_chunk(input logic [127:0] a, input logic [127:0] b, input int k);
    return {el(a, k, 0), el(a, k, 1), el(a, k, 2), el(a, k, 3),
            el(b, 0, k), el(b, 1, k), el(b, 2, k), el(b, 3, k)};
  endfunction

  // Accelerator stand-in: rebuild A and B from the chunks it was sent and multiply.
  task automatic model_c();
    logic [31:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int i = 0; i < 4; i++)
          s += 32'(seen_ch[r][63-8*i -: 8]) * 32'(seen_ch[c][31-8*i -: 8]);
        m_c[4*r+c] = s;
      end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int n_strobe, sent, ph, done_n, err_n, kick_n;
    int ready_cyc, err_cyc, cap_cyc, done_cyc, end_cyc;
    n_strobe = 0; sent = 0; ph = 0; done_n = 0; err_n = 0; kick_n = 0;
    ready_cyc = -1; err_cyc = -1; cap_cyc = -1; done_cyc = -1; end_cyc = -1;
    exp_chunk_q.delete();
    exp_elem_q.delete();
    for (int k = 0; k < 4; k++) exp_chunk_q.push_back(exp_chunk(v.a, v.b, k));
    for (int e = 0; e < 16; e++) exp_elem_q.push_back(gold(v.a, v.b, e / 4, e % 4));
    a_mat = v.a;
    b_mat = v.b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (acc_valid_in) begin
        kick_n++;
        chk({tag, " kick cycle"}, 64'(cyc), 64'd1);
      end
      if (acc_src_valid) begin
        chk({tag, " strobe cycle"}, 64'(cyc), 64'(3 + n_strobe * (2 + GAP_T)));
        if (exp_chunk_q.size() == 0) chk({tag, " extra strobe"}, 64'(n_strobe), 64'd3);
        else chk({tag, " chunk data"}, acc_data_in, exp_chunk_q.pop_front());
        if (n_strobe < 4) seen_ch[n_strobe] = acc_data_in;
        n_strobe++;
        if (n_strobe == 4) model_c();
      end
      if (acc_src_ready && ready_cyc < 0) ready_cyc = cyc;
      if (done) begin done_n++; done_cyc = cyc; end
      if (err) begin err_n++; err_cyc = cyc; end
      if (!busy) begin end_cyc = cyc; break; end
      start = v.restart && (cyc == 5 || cyc == 20);
      acc_out_valid = 1'b0;
      if (acc_src_ready) begin
        if (sent < v.stop && (v.pat == 0 || ph % 3 == 0)) begin
          acc_out_valid      = 1'b1;
          acc_final_data_out = {m_c[2*sent], m_c[2*sent+1]};
          sent++;
          cap_cyc = cyc;
        end
        ph++;
      end else begin
        // Junk offered while not receiving must be ignored.
        acc_out_valid      = cyc[0];
        acc_final_data_out = 64'hDEAD_BEEF_0BAD_F00D;
      end
      @(negedge clk);
    end
    acc_out_valid = 1'b0;
    start = 1'b0;
    chk({tag, " job ended"}, 64'(end_cyc > 0), 64'd1);
    chk({tag, " kick count"}, 64'(kick_n), 64'd1);
    chk({tag, " strobe count"}, 64'(n_strobe), 64'd4);
    chk({tag, " ready cycle"}, 64'(ready_cyc), 64'(2 + 4 * (2 + GAP_T)));
    chk({tag, " done count"}, 64'(done_n), 64'(v.stop == 8));
    chk({tag, " err count"}, 64'(err_n), 64'(v.stop < 8));
    if (v.stop == 8) begin
      chk({tag, " done timing"}, 64'(done_cyc), 64'(cap_cyc + 1));
      chk({tag, " busy drop"}, 64'(end_cyc), 64'(cap_cyc + 2));
    end else begin
      chk({tag, " err timing"}, 64'(err_cyc), 64'(cap_cyc + TO_T + 1));
      chk({tag, " busy drop"}, 64'(end_cyc), 64'(cap_cyc + TO_T + 2));
    end
    for (int e = 0; e < 16; e++) begin
      logic [31:0] x;
      x = exp_elem_q.pop_front();
      if (e >= 2 * v.stop) x = 32'd0;
      chk($sformatf("%s elem %0d", tag, e), 64'(result[32*e +: 32]), 64'(x));
    end
    chk({tag, " c00"}, 64'(result[31:0]), 64'(v.c00));
    chk({tag, " c03"}, 64'(result[127:96]), 64'(v.c03));
    chk({tag, " c30"}, 64'(result[415:384]), 64'(v.c30));
    chk({tag, " c33"}, 64'(result[511:480]), 64'(v.c33));
  endtask

  initial begin
    logic [127:0] seq_m, id_m, ff_m;
    int g_strobe, g_done, g_ready, g_sent;
    for (int i = 0; i < 16; i++) seq_m[8*i +: 8] = 8'(i + 1);
    id_m = '0;
    for (int i = 0; i < 4; i++) id_m[8*(5*i) +: 8] = 8'd1;
    ff_m = {128{1'b1}};
    //          a      b      pat stop restart c00          c03          c30          c33
    vecs[0] = '{seq_m, seq_m, 0,  8,   1'b0,   32'd90,      32'd120,     32'd426,     32'd600};
    vecs[1] = '{id_m,  seq_m, 0,  8,   1'b0,   32'd1,       32'd4,       32'd13,      32'd16};
    vecs[2] = '{ff_m,  ff_m,  0,  8,   1'b0,   32'd260100,  32'd260100,  32'd260100,  32'd260100};
    vecs[3] = '{seq_m, seq_m, 1,  8,   1'b0,   32'd90,      32'd120,     32'd426,     32'd600};
    vecs[4] = '{seq_m, seq_m, 0,  8,   1'b1,   32'd90,      32'd120,     32'd426,     32'd600};
    vecs[5] = '{seq_m, seq_m, 0,  3,   1'b0,   32'd90,      32'd120,     32'd0,       32'd0};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset outputs", 64'({done, err, acc_valid_in, acc_src_valid, acc_src_ready}), 64'd0);
    chk("reset data", acc_data_in, 64'd0);
    chk("reset result", 64'(|result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    chk("chunk0 const", exp_chunk(seq_m, seq_m, 0), 64'h01020304_0105090D);
    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v], $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Reset in the STROBE cycle of chunk 2 must clear everything at once.
    a_mat = seq_m; b_mat = seq_m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre-reset strobe", 64'(acc_src_valid), 64'd1);
    chk("pre-reset chunk2", acc_data_in, exp_chunk(seq_m, seq_m, 2));
    reset = 1'b1;
    #1;
    chk("async busy", 64'(busy), 64'd0);
    chk("async strobe", 64'(acc_src_valid), 64'd0);
    chk("async data", acc_data_in, 64'd0);
    chk("async flags", 64'({done, err, acc_valid_in, acc_src_ready}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_job(vecs[0], "post-reset");
    repeat (2) @(negedge clk);

    // Narrow-gap build: strobes three cycles apart, same product.
    g_strobe = 0; g_done = 0; g_ready = -1; g_sent = 0;
    a_mat = seq_m; b_mat = seq_m; start_g = 1'b1;
    @(negedge clk);
    start_g = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (acc_src_valid_g) begin
        chk("g1 strobe cycle", 64'(cyc), 64'(3 + 3 * g_strobe));
        g_strobe++;
      end
      if (acc_src_ready_g && g_ready < 0) g_ready = cyc;
      if (done_g) g_done++;
      if (!busy_g) break;
      acc_out_valid_g = 1'b0;
      if (acc_src_ready_g && g_sent < 8) begin
        acc_out_valid_g      = 1'b1;
        acc_final_data_out_g = {gold(seq_m, seq_m, (2*g_sent) / 4, (2*g_sent) % 4),
                                gold(seq_m, seq_m, (2*g_sent+1) / 4, (2*g_sent+1) % 4)};
        g_sent++;
      end
      @(negedge clk);
    end
    acc_out_valid_g = 1'b0;
    chk("g1 busy dropped", 64'(busy_g), 64'd0);
    chk("g1 strobes", 64'(g_strobe), 64'd4);
    chk("g1 ready cycle", 64'(g_ready), 64'd14);
    chk("g1 done count", 64'(g_done), 64'd1);
    chk("g1 c00", 64'(result_g[31:0]), 64'd90);
    chk("g1 c03", 64'(result_g[127:96]), 64'd120);
    chk("g1 c30", 64'(result_g[415:384]), 64'd426);
    chk("g1 c33", 64'(result_g[511:480]), 64'd600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
